bcd_seq_ctrl: RTL and testbench
===============================

BCD_SEQ_CTRL -- requirements
Module: bcd_seq_ctrl

Interface
REQ-001 Parameter BITS, default 8, binary operand width; legal range 4..8; other values SHALL be rejected at elaboration.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 start  input  1  request to convert operand; sampled on rising edge.
REQ-005 number  input  BITS  unsigned binary operand; sampled only on the accepting edge.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 done  output  1  one-cycle pulse; results valid and newly updated.
REQ-008 hundreds  output  4  BCD hundreds digit of last completed conversion.
REQ-009 tens  output  4  BCD tens digit of last completed conversion.
REQ-010 units  output  4  BCD units digit of last completed conversion.

Function
REQ-011 The block SHALL perform sequential shift-add-three (double dabble) conversion of number to three BCD digits, one algorithm phase per clock.
REQ-012 FSM states SHALL be IDLE, ADJ, SHF, DONE; all outputs SHALL be registered.
REQ-013 IDLE: start=1 at an edge -> load internal shift register with number, clear working digits, bit counter = BITS, go to ADJ; start=0 -> stay IDLE.
REQ-014 ADJ: each working digit (units, tens, hundreds) >= 5 SHALL get +3 (4-bit result); next state SHF.
REQ-015 SHF: shift {hundreds,tens,units,operand} left by one as one vector; counter decrements; counter reaching 0 -> DONE, else -> ADJ.
REQ-016 ADJ and SHF SHALL alternate exactly BITS times each; no state skipped for any operand value, including 0.
REQ-017 On the edge entering DONE, hundreds/tens/units outputs SHALL load the working digits.
REQ-018 Latency: accepting edge E0 -> done high in cycle after edge E(2*BITS) (E16 for BITS=8).
REQ-019 busy SHALL be high in ADJ and SHF only; low in IDLE and DONE.
REQ-020 done SHALL be high only in DONE, exactly one cycle per conversion.
REQ-021 DONE: start=1 -> accept new operand (as REQ-013) and go to ADJ (back-to-back); start=0 -> IDLE.
REQ-022 start while busy=1 SHALL be ignored; number changes while busy SHALL NOT affect the result.
REQ-023 Outputs SHALL hold last completed result until the next DONE entry; they SHALL NOT change during ADJ/SHF.
REQ-024 Hundreds digit SHALL be 0..2 for BITS=8, 0 for BITS<=6; no overflow condition exists.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, busy=0, done=0, hundreds=tens=units=0, counter and shift register cleared.
REQ-026 reset SHALL take priority over start and over any in-progress conversion; an aborted conversion SHALL produce no done pulse.
REQ-027 start sampled on the same edge as reset SHALL be ignored.

Verification
REQ-028 BITS=8, start pulse with number=255 -> busy high 16 cycles, done one cycle after E16, hundreds=2 tens=5 units=5.
REQ-029 BITS=8, number=0 -> same 16-cycle latency, outputs 0/0/0, done single pulse.
REQ-030 BITS=8, number=99 accepted, then start with number=200 pulsed at E5 -> ignored; result 0/9/9, exactly one done.
REQ-031 BITS=8, number=128, reset asserted at E7 -> busy=0, outputs 0/0/0, no done; subsequent start number=47 -> 0/4/7.
REQ-032 BITS=8, start held high continuously with number=13 then 250 at DONE -> done pulses every 17 cycles, results 0/1/3 then 2/5/0.
REQ-033 BITS=4, number=15 -> done after E8, hundreds=0 tens=1 units=5; exhaustive sweep 0..15 matches decimal reference.

Source files
------------

// File: rtl/bcd_seq_ctrl.sv
// Sequential binary-to-BCD converter (double dabble), one ADJ or SHF phase per clock.
// Produces three BCD digits for a BITS-wide unsigned operand; all outputs registered.
module bcd_seq_ctrl #(
   parameter int unsigned BITS = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [BITS-1:0] number,
   output logic            busy,
   output logic            done,
   output logic [3:0]      hundreds,
   output logic [3:0]      tens,
   output logic [3:0]      units
);

   if ((BITS < 4) || (BITS > 8)) begin : g_bits_check
      $error("bcd_seq_ctrl: BITS must be in 4..8");
   end

   typedef enum logic [1:0] {IDLE, ADJ, SHF, DONE} state_t;

   state_t          state_q, state_d;
   logic [BITS-1:0] opnd_q, opnd_d;
   logic [11:0]     dig_q, dig_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [3:0]      hundreds_q, hundreds_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      units_q, units_d;
   logic [BITS+11:0] shifted;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   always_comb begin
      state_d    = state_q;
      opnd_d     = opnd_q;
      dig_d      = dig_q;
      cnt_d      = cnt_q;
      hundreds_d = hundreds_q;
      tens_d     = tens_q;
      units_d    = units_q;
      shifted    = {dig_q, opnd_q} << 1;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               opnd_d  = number;
               dig_d   = '0;
               cnt_d   = 4'(BITS);
               state_d = ADJ;
            end else begin
               state_d = IDLE;
            end
         end
         ADJ: begin
            dig_d   = {add3(dig_q[11:8]), add3(dig_q[7:4]), add3(dig_q[3:0])};
            state_d = SHF;
         end
         SHF: begin
            dig_d  = shifted[BITS+11:BITS];
            opnd_d = shifted[BITS-1:0];
            cnt_d  = cnt_q - 4'd1;
            if (cnt_d == '0) begin
               state_d    = DONE;
               // Result digits come from the shifted vector, i.e. the final working digits.
               hundreds_d = shifted[BITS+11:BITS+8];
               tens_d     = shifted[BITS+7:BITS+4];
               units_d    = shifted[BITS+3:BITS];
            end else begin
               state_d = ADJ;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ADJ) || (state_d == SHF);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         opnd_q     <= '0;
         dig_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         hundreds_q <= '0;
         tens_q     <= '0;
         units_q    <= '0;
      end else begin
         state_q    <= state_d;
         opnd_q     <= opnd_d;
         dig_q      <= dig_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         hundreds_q <= hundreds_d;
         tens_q     <= tens_d;
         units_q    <= units_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign hundreds = hundreds_q;
   assign tens     = tens_q;
   assign units    = units_q;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Directed bench for bcd_seq_ctrl: an 8-bit and a 4-bit instance on a shared clock/reset,
// expected digits and cycle timing written out by hand or from a decimal reference.
module tb_bcd_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start8 = 1'b0;
   logic [7:0] number8 = '0;
   logic       busy8, done8;
   logic [3:0] h8, t8, u8;
   logic       start4 = 1'b0;
   logic [3:0] number4 = '0;
   logic       busy4, done4;
   logic [3:0] h4, t4, u4;

   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;

   always #5 clk = ~clk;

   bcd_seq_ctrl #(.BITS(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .number(number8),
      .busy(busy8), .done(done8), .hundreds(h8), .tens(t8), .units(u8)
   );

   bcd_seq_ctrl #(.BITS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .number(number4),
      .busy(busy4), .done(done4), .hundreds(h4), .tens(t4), .units(u4)
   );

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_dig8(input string tag, input int h, input int t, input int u);
      chk({tag, ".h"}, 32'(h8), 32'(h));
      chk({tag, ".t"}, 32'(t8), 32'(t));
      chk({tag, ".u"}, 32'(u8), 32'(u));
   endtask

   // One 8-bit conversion checked cycle by cycle; poke>0 pulses start (number=200) at edge E(poke+1).
   task automatic conv8(input string tag, input logic [7:0] n, input int eh, input int et, input int eu,
                        input int ph, input int pt, input int pu, input int poke);
      start8  = 1'b1;
      number8 = n;
      step();
      start8  = 1'b0;
      number8 = ~n;
      chk({tag, ".busy_e0"}, 32'(busy8), 1);
      chk({tag, ".done_e0"}, 32'(done8), 0);
      for (int k = 1; k <= 15; k++) begin
         step();
         if (k == poke + 1) begin
            start8 = 1'b0;
         end
         chk({tag, ".busy_run"}, 32'(busy8), 1);
         chk({tag, ".done_run"}, 32'(done8), 0);
         chk_dig8({tag, ".hold"}, ph, pt, pu);
         if (k == poke) begin
            start8  = 1'b1;
            number8 = 8'd200;
         end
      end
      step();
      chk({tag, ".done_e16"}, 32'(done8), 1);
      chk({tag, ".busy_e16"}, 32'(busy8), 0);
      chk_dig8({tag, ".res"}, eh, et, eu);
      step();
      chk({tag, ".done_e17"}, 32'(done8), 0);
      chk({tag, ".busy_e17"}, 32'(busy8), 0);
      chk_dig8({tag, ".keep"}, eh, et, eu);
   endtask

   task automatic conv4(input string tag, input logic [3:0] n);
      int cyc;
      start4  = 1'b1;
      number4 = n;
      step();
      start4  = 1'b0;
      number4 = ~n;
      chk({tag, ".busy_e0"}, 32'(busy4), 1);
      cyc = 0;
      while (!done4 && cyc < 20) begin
         step();
         cyc++;
      end
      chk({tag, ".latency"}, 32'(cyc), 8);
      chk({tag, ".h"}, 32'(h4), 32'(int'(n) / 100));
      chk({tag, ".t"}, 32'(t4), 32'((int'(n) / 10) % 10));
      chk({tag, ".u"}, 32'(u4), 32'(int'(n) % 10));
      step();
      chk({tag, ".done_off"}, 32'(done4), 0);
   endtask

   initial begin
      int dcount;

      // Reset with start asserted on the same edges: start must be ignored.
      reset   = 1'b1;
      start8  = 1'b1;
      number8 = 8'd77;
      start4  = 1'b1;
      number4 = 4'd9;
      step();
      step();
      chk("rst.busy8", 32'(busy8), 0);
      chk("rst.done8", 32'(done8), 0);
      chk_dig8("rst", 0, 0, 0);
      chk("rst.busy4", 32'(busy4), 0);
      chk("rst.done4", 32'(done4), 0);
      chk("rst.dig4", 32'({h4, t4, u4}), 0);
      reset  = 1'b0;
      start8 = 1'b0;
      start4 = 1'b0;
      step();
      chk("post_rst.busy8", 32'(busy8), 0);
      chk("post_rst.busy4", 32'(busy4), 0);

      conv8("n255", 8'd255, 2, 5, 5, 0, 0, 0, 0);
      conv8("n0", 8'd0, 0, 0, 0, 2, 5, 5, 0);
      conv8("n99", 8'd99, 0, 9, 9, 0, 0, 0, 4);
      step();
      chk("n99.single_done", 32'(done8), 0);
      chk("n99.idle", 32'(busy8), 0);

      // Abort a conversion with reset mid-flight.
      start8  = 1'b1;
      number8 = 8'd128;
      step();
      start8  = 1'b0;
      repeat (6) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort.busy", 32'(busy8), 0);
      chk("abort.done", 32'(done8), 0);
      chk_dig8("abort", 0, 0, 0);
      dcount = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done8) dcount++;
      end
      chk("abort.no_done", 32'(dcount), 0);
      conv8("n47", 8'd47, 0, 4, 7, 0, 0, 0, 0);

      // Start held high: back-to-back conversions from DONE.
      start8  = 1'b1;
      number8 = 8'd13;
      step();
      number8 = 8'd250;
      repeat (15) step();
      chk("b2b.pre_done", 32'(done8), 0);
      step();
      chk("b2b.done1", 32'(done8), 1);
      chk_dig8("b2b.r1", 0, 1, 3);
      step();
      chk("b2b.done1_off", 32'(done8), 0);
      chk("b2b.busy2", 32'(busy8), 1);
      chk_dig8("b2b.hold", 0, 1, 3);
      repeat (15) step();
      chk("b2b.pre_done2", 32'(done8), 0);
      step();
      chk("b2b.done2", 32'(done8), 1);
      chk_dig8("b2b.r2", 2, 5, 0);
      start8 = 1'b0;
      step();
      chk("b2b.end_done", 32'(done8), 0);
      chk("b2b.end_busy", 32'(busy8), 0);

      conv4("w4_n15", 4'd15);
      chk("w4_n15.t_const", 32'(t4), 1);
      chk("w4_n15.u_const", 32'(u4), 5);
      for (int n = 0; n < 16; n++) begin
         conv4("w4_sweep", 4'(n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
